// File: rtl/spi_bus_arbiter.sv
// rtl/spi_bus_arbiter.sv - two-master Wishbone arbiter in front of a shared SPI SRAM controller
//
// Purpose: grants the shared controller to one of two Wishbone masters. A grant
//   is held for the whole bus cycle, with no preemption. The arbiter inserts a
//   one-cycle idle gap between grants. It alternates priority under contention
//   and aborts a beat that the controller leaves stalled for TIMEOUT cycles.
// Parameters:
//   TIMEOUT   stalled cycles per beat before abort (0 disables the watchdog)
// Ports:
//   clk_i, rst_ni                   clock, asynchronous active-low reset
//   mN_cyc_i/stb_i/we_i/adr_i/dat_i master N request (N = 0,1)
//   mN_ack_o/err_o/dat_o            master N response
//   s_cyc_o/stb_o/we_o/adr_o/dat_o  request to the controller
//   s_ack_i/err_i/dat_i             controller response
module spi_bus_arbiter #(
  parameter int TIMEOUT = 128
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  input  logic [23:0] m0_adr_i,
  input  logic [7:0]  m0_dat_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [7:0]  m0_dat_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [23:0] m1_adr_i,
  input  logic [7:0]  m1_dat_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [7:0]  m1_dat_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [23:0] s_adr_o,
  output logic [7:0]  s_dat_o,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic [7:0]  s_dat_i
);

  localparam int            CW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit            WD_EN   = (TIMEOUT > 0);
  localparam logic [CW-1:0] WD_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] WD_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GNT0,
    S_GNT1,
    S_ABORT,
    S_GAP
  } state_t;

  state_t        state;
  logic          prio;      // 0 favours m0 on contention
  logic [CW-1:0] wd_cnt;    // stalled cycles already seen in this beat

  logic gnt0, gnt1, granted;
  logic cur_cyc, cur_stb;
  logic stall, timeout;

  assign gnt0    = (state == S_GNT0);
  assign gnt1    = (state == S_GNT1);
  assign granted = gnt0 | gnt1;
  assign cur_cyc = gnt1 ? m1_cyc_i : m0_cyc_i;
  assign cur_stb = gnt1 ? m1_stb_i : m0_stb_i;

  assign stall   = granted & cur_cyc & cur_stb & ~s_ack_i & ~s_err_i;
  // wd_cnt excludes the current cycle, so hitting WD_LAST while stalled means
  // this is the TIMEOUT-th stalled cycle. A same-cycle ack clears stall, so ack wins.
  assign timeout = WD_EN & stall & (wd_cnt == WD_LAST);

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    if (gnt0) begin
      s_cyc_o = m0_cyc_i;
      s_stb_o = m0_stb_i;
      s_we_o  = m0_we_i;
      s_adr_o = m0_adr_i;
      s_dat_o = m0_dat_i;
    end else if (gnt1) begin
      s_cyc_o = m1_cyc_i;
      s_stb_o = m1_stb_i;
      s_we_o  = m1_we_i;
      s_adr_o = m1_adr_i;
      s_dat_o = m1_dat_i;
    end
  end

  assign m0_ack_o = gnt0 & s_ack_i;
  assign m0_err_o = gnt0 & (s_err_i | timeout);
  assign m0_dat_o = gnt0 ? s_dat_i : 8'h00;
  assign m1_ack_o = gnt1 & s_ack_i;
  assign m1_err_o = gnt1 & (s_err_i | timeout);
  assign m1_dat_o = gnt1 ? s_dat_i : 8'h00;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= S_IDLE;
      prio   <= 1'b0;
      wd_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // Every grant is entered from here, so the watchdog starts each grant at zero.
          wd_cnt <= '0;
          if (m0_cyc_i && m1_cyc_i) state <= prio ? S_GNT1 : S_GNT0;
          else if (m0_cyc_i)        state <= S_GNT0;
          else if (m1_cyc_i)        state <= S_GNT1;
        end
        S_GNT0, S_GNT1: begin
          if (s_ack_i || s_err_i)           wd_cnt <= '0;
          else if (stall && wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
          if (!cur_cyc) begin
            state <= S_GAP;
            prio  <= gnt0;
          end else if (timeout) begin
            state <= S_ABORT;
            prio  <= gnt0;
          end
        end
        S_ABORT: begin
          // prio was set to ~N on abort, so the aborted master is the one not favoured.
          if (!(prio ? m0_cyc_i : m1_cyc_i)) state <= S_GAP;
        end
        S_GAP:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// tb/tb_spi_bus_arbiter.sv - scoreboard bench for spi_bus_arbiter
module tb_spi_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        m0_cyc = 0, m0_stb = 0, m0_we = 0;
  logic [23:0] m0_adr = '0;
  logic [7:0]  m0_dat = '0;
  logic        m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [23:0] m1_adr = '0;
  logic [7:0]  m1_dat = '0;
  logic        s_ack = 0, s_err = 0;
  logic [7:0]  s_dat = '0;

  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [7:0]  m0_dat_o, m1_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o;
  logic [23:0] s_adr_o;
  logic [7:0]  s_dat_o;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    int         master;
    bit         err;
    logic [7:0] dat;
  } resp_t;
  resp_t sb_q[$];

  spi_bus_arbiter #(.TIMEOUT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr), .m0_dat_i(m0_dat),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_dat_o(m0_dat_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr), .m1_dat_i(m1_dat),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_dat_o(m1_dat_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
    .s_ack_i(s_ack), .s_err_i(s_err), .s_dat_i(s_dat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic push(input int master, input bit err, input logic [7:0] dat);
    resp_t e;
    e.master = master;
    e.err    = err;
    e.dat    = dat;
    sb_q.push_back(e);
  endtask

  task automatic clear_inputs();
    m0_cyc = 0; m0_stb = 0; m0_we = 0; m0_adr = '0; m0_dat = '0;
    m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_adr = '0; m1_dat = '0;
    s_ack = 0; s_err = 0; s_dat = '0;
  endtask

  task automatic do_reset();
    tick();
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic check_resp(input int master, input logic ack, input logic err, input logic [7:0] dat);
    resp_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL unexpected_resp: m%0d ack=%0b err=%0b dat=0x%0h, none expected", master, ack, err, dat);
    end else begin
      e = sb_q.pop_front();
      if (e.master != master || e.err != err || ack != !e.err || (!e.err && dat !== e.dat)) begin
        n_fail++;
        $display("FAIL resp: got m%0d ack=%0b err=%0b dat=0x%0h expected m%0d err=%0b dat=0x%0h",
                 master, ack, err, dat, e.master, e.err, e.dat);
      end
    end
  endtask

  // Monitor: every response the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (m0_ack_o || m0_err_o) check_resp(0, m0_ack_o, m0_err_o, m0_dat_o);
    if (m1_ack_o || m1_err_o) check_resp(1, m1_ack_o, m1_err_o, m1_dat_o);
  end

  initial begin
    // Reset asserted with live requests and a stray ack: everything stays 0.
    m0_cyc = 1; m0_stb = 1; s_ack = 1; s_dat = 8'hFF;
    #3;
    chk("rst_s_cyc", {31'd0, s_cyc_o}, 0);
    chk("rst_m0_ack", {31'd0, m0_ack_o}, 0);
    chk("rst_m0_dat", {24'd0, m0_dat_o}, 0);
    clear_inputs();
    #9 rst_n = 1'b1;

    // Single read by m0 with one-cycle grant latency.
    tick();
    m0_cyc = 1; m0_stb = 1; m0_we = 0; m0_adr = 24'h000123;
    sample();
    chk("a_latency_cyc0", {31'd0, s_cyc_o}, 0);
    tick();
    s_ack = 1; s_dat = 8'hA5; push(0, 0, 8'hA5);
    sample();
    chk("a_s_cyc", {31'd0, s_cyc_o}, 1);
    chk("a_s_adr", {8'd0, s_adr_o}, 32'h000123);
    chk("a_m1_ack", {31'd0, m1_ack_o}, 0);
    chk("a_m1_dat", {24'd0, m1_dat_o}, 0);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick(); tick();

    // Simultaneous requests from reset: m0 first, gap, m1, then m0 favoured again.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_we = 1; m0_adr = 24'h000010; m0_dat = 8'h01;
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_adr = 24'h000020; m1_dat = 8'h02;
    tick();
    s_ack = 1; s_dat = 8'h11; push(0, 0, 8'h11);
    sample();
    chk("b_first_m0", {8'd0, s_adr_o}, 32'h10);
    chk("b_s_dat", {24'd0, s_dat_o}, 32'h01);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick();
    sample();
    chk("b_gap_cyc", {31'd0, s_cyc_o}, 0);
    tick();
    tick();
    s_ack = 1; s_dat = 8'h22; push(1, 0, 8'h22);
    sample();
    chk("b_then_m1", {8'd0, s_adr_o}, 32'h20);
    tick();
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    tick();
    s_ack = 1; s_dat = 8'h33; push(0, 0, 8'h33);
    sample();
    chk("b_prio_back_m0", {8'd0, s_adr_o}, 32'h10);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0;
    tick(); tick();

    // m1 holds its cycle for three beats while m0 waits.
    do_reset();
    m1_cyc = 1; m1_stb = 1; m1_adr = 24'h000030;
    tick();
    m0_cyc = 1; m0_stb = 1; m0_adr = 24'h000040;
    for (int i = 0; i < 3; i++) begin
      s_ack = 1; s_dat = 8'h40 + 8'(i); push(1, 0, 8'h40 + 8'(i));
      sample();
      chk("c_beat_m1", {8'd0, s_adr_o}, 32'h30);
      tick();
    end
    s_ack = 0; m1_cyc = 0; m1_stb = 0;
    tick();
    sample();
    chk("c_gap_cyc", {31'd0, s_cyc_o}, 0);
    tick(); tick();
    s_ack = 1; s_dat = 8'h50; push(0, 0, 8'h50);
    sample();
    chk("c_then_m0", {8'd0, s_adr_o}, 32'h40);
    tick();
    s_ack = 0; m0_cyc = 0; m0_stb = 0;
    tick(); tick();

    // Controller never answers: error on the 8th stalled cycle, then abort.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 24'h000050; s_dat = 8'h5A;
    tick();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) push(0, 1, 8'h00);
      sample();
      tick();
    end
    sample();
    chk("d_abort_cyc", {31'd0, s_cyc_o}, 0);
    chk("d_abort_err", {31'd0, m0_err_o}, 0);
    tick();
    sample();
    chk("d_abort_hold", {31'd0, s_cyc_o}, 0);
    m0_cyc = 0; m0_stb = 0;
    tick(); tick(); tick();

    // Ack on exactly the 8th cycle wins over the watchdog.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 24'h000060;
    tick();
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) begin
        s_ack = 1; s_dat = 8'h77; push(0, 0, 8'h77);
      end
      sample();
      tick();
    end
    s_ack = 0;
    sample();
    chk("e_no_abort", {31'd0, s_cyc_o}, 1);
    tick();
    m0_cyc = 0; m0_stb = 0;
    tick(); tick(); tick();

    // Reset mid-beat clears outputs with no clock edge; regrant after release.
    do_reset();
    m0_cyc = 1; m0_stb = 1; m0_adr = 24'h000070;
    tick();
    s_ack = 1; s_dat = 8'h99;
    #1 rst_n = 1'b0;
    #1;
    chk("f_rst_cyc", {31'd0, s_cyc_o}, 0);
    chk("f_rst_ack", {31'd0, m0_ack_o}, 0);
    chk("f_rst_adr", {8'd0, s_adr_o}, 0);
    s_ack = 0;
    #1 rst_n = 1'b1;
    #1;
    chk("f_idle_after", {31'd0, s_cyc_o}, 0);
    tick();
    sample();
    chk("f_regrant", {31'd0, s_cyc_o}, 1);
    m0_cyc = 0; m0_stb = 0;
    tick(); tick(); tick();

    chk("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 128, max slave wait cycles per beat before abort (0 = watchdog disabled).
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk_i  input  1  rising-edge clock for all state.
REQ-004 rst_ni  input  1  asynchronous active-low reset.
REQ-005 mN_cyc_i / mN_stb_i / mN_we_i  input  1 each  Wishbone cycle, strobe and write-enable of master N (N = 0,1).
REQ-006 mN_adr_i  input  24  byte address of master N.
REQ-007 mN_dat_i  input  8  write data of master N.
REQ-008 mN_ack_o / mN_err_o  output  1 each  acknowledge and error to master N.
REQ-009 mN_dat_o  output  8  read data to master N.
REQ-010 s_cyc_o / s_stb_o / s_we_o  output  1 each  to the shared SPI SRAM controller.
REQ-011 s_adr_o  output  24; s_dat_o  output  8  address and write data to controller.
REQ-012 s_ack_i / s_err_i  input  1 each; s_dat_i  input  8  controller responses.

Function
REQ-013 SHALL implement states IDLE, GNT0, GNT1, ABORT, GAP; state register and priority bit prio (0 = m0 favoured) are the only arbitration state.
REQ-014 IDLE: m0_cyc_i only -> GNT0; m1_cyc_i only -> GNT1; both -> GNT<prio>; neither -> stay; transition takes effect next clock (1-cycle grant latency).
REQ-015 In IDLE, GAP and ABORT: s_cyc_o = s_stb_o = s_we_o = 0, s_adr_o = 0, s_dat_o = 0.
REQ-016 In GNTn: s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o SHALL combinationally equal master N's inputs.
REQ-017 In GNTn: mN_ack_o = s_ack_i, mN_err_o = s_err_i; non-granted master's ack/err SHALL be 0 in every state.
REQ-018 mN_dat_o SHALL equal s_dat_i while GNTn, else 0.
REQ-019 Grant SHALL persist across any number of beats while mN_cyc_i stays high; no preemption.
REQ-020 GNTn with mN_cyc_i = 0 -> GAP, prio <= ~N; GAP lasts exactly 1 cycle, then IDLE (guarantees controller sees cyc low and deselects chip).
REQ-021 Watchdog counter SHALL clear on grant entry and on any cycle with s_ack_i or s_err_i, increment each cycle in GNTn with s_cyc_o & s_stb_o & !s_ack_i & !s_err_i, saturate, width ceil(log2(TIMEOUT+1)).
REQ-022 When counter = TIMEOUT (TIMEOUT > 0) in GNTn: mN_err_o = 1 that cycle, -> ABORT, prio <= ~N.
REQ-023 s_ack_i and timeout in the same cycle: ack SHALL win; no err, counter clears.
REQ-024 ABORT: hold slave outputs low until mN_cyc_i = 0, then -> GAP; mN_ack_o/mN_err_o = 0 during ABORT.
REQ-025 Request from the other master during GNTn/ABORT/GAP SHALL wait; it is served in IDLE per REQ-014.
REQ-026 Acks arriving in IDLE/GAP/ABORT SHALL be discarded.

Reset
REQ-027 rst_ni low SHALL asynchronously force state IDLE, prio 0, counter 0; all outputs 0 while asserted.
REQ-028 Reset mid-transaction SHALL abandon the grant with no ack/err; first grant after release follows REQ-014.

Verification
REQ-029 m0 single read adr 0x000123, controller acks with 0xA5 -> s_cyc_o rises 1 cycle after m0_cyc_i, m0_dat_o = 0xA5 with m0_ack_o, m1 outputs 0.
REQ-030 m0, m1 request same cycle from reset -> m0 served first; after m0 drops cyc, 1 GAP cycle with s_cyc_o = 0, then m1 granted; next contention favours m0.
REQ-031 m1 holds cyc for 3 beats while m0 requests -> all 3 beats to m1, m0 granted only after GAP.
REQ-032 TIMEOUT = 8, controller never acks -> m0_err_o pulses 1 cycle on 8th stalled cycle, s_cyc_o low next cycle, stays low until m0_cyc_i drops.
REQ-033 TIMEOUT = 8, s_ack_i on exactly the 8th stalled cycle -> m0_ack_o = 1, m0_err_o = 0.
REQ-034 rst_ni pulled low mid-beat -> all outputs 0 immediately (no clock edge), state IDLE after release.
